// File: rtl/ddrc_apb_reg_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ddrc_apb_resp_pkg
// Brief    : Register offsets, field positions and FSM encoding shared by the
//            DDRC APB register responder.
// Revision : 1.0 - initial release
// ============================================================================
package ddrc_apb_resp_pkg;

  localparam logic [31:0] CTRL_OFS = 32'h0000_0000;
  localparam logic [31:0] STAT_OFS = 32'h0000_0004;

  localparam int CTRL_RST_BIT   = 0;
  localparam int CTRL_START_BIT = 1;
  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_DONE_BIT  = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage
`default_nettype wire

// File: rtl/ddrc_apb_reg_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : ddrc_apb_reg_responder_if
// Brief    : APB3 bus bundle; carries pstrb when APB_PSTRB_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface ddrc_apb_reg_responder_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;
`ifdef APB_PSTRB_EN
  logic [DATA_W/8-1:0] pstrb;

  modport master (output psel, penable, pwrite, paddr, pwdata, pstrb,
                  input  prdata, pready, pslverr);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata, pstrb,
                  output prdata, pready, pslverr);
`else
  modport master (output psel, penable, pwrite, paddr, pwdata,
                  input  prdata, pready, pslverr);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                  output prdata, pready, pslverr);
`endif
endinterface
`default_nettype wire

// File: rtl/ddrc_apb_reg_responder_init_timer.sv
`default_nettype none
// ============================================================================
// Module   : ddrc_init_timer
// Brief    : Init-done countdown with busy flag and sticky done flag.
// Revision : 1.0 - initial release
// ============================================================================
module ddrc_init_timer #(
  parameter int INIT_LATENCY = 16
) (
  input  logic pclk,
  input  logic preset,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done
);

  localparam int LAT_EFF = (INIT_LATENCY < 1) ? 1 : INIT_LATENCY;
  localparam int CNT_W   = (LAT_EFF > 1) ? $clog2(LAT_EFF) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // abort has priority so a combined reset+start never launches a countdown
  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = done_q;
    if (abort) begin
      cnt_d  = '0;
      busy_d = 1'b0;
      done_d = 1'b0;
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end else if (start) begin
      busy_d = 1'b1;
      cnt_d  = CNT_W'(LAT_EFF - 1);
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule
`default_nettype wire

// File: rtl/ddrc_apb_reg_responder.sv
`default_nettype none
// ============================================================================
// Module   : ddrc_apb_reg_responder
// Brief    : APB3 completer modelling the DDRC config space, with wait states,
//            error response and an init handshake. Byte strobes: APB_PSTRB_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ddrc_apb_reg_responder
  import ddrc_apb_resp_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int NUM_REGS     = 64,
  parameter int WAIT_CYCLES  = 1,
  parameter int INIT_LATENCY = 16
) (
  input  logic                      pclk,
  input  logic                      preset,
  ddrc_apb_reg_responder_if.slave   apb,
  output logic                      ddrc_rst_o,
  output logic                      init_busy,
  output logic                      init_done
);

  localparam int NBYTES = DATA_W / 8;
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int WCNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [IDX_W-1:0] CTRL_IDX = IDX_W'(CTRL_OFS >> 2);
  localparam logic [IDX_W-1:0] STAT_IDX = IDX_W'(STAT_OFS >> 2);

  apb_state_e        state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic [NBYTES-1:0] strb_q, strb_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  logic [NBYTES-1:0] strb_in;
  logic [IDX_W-1:0]  idx;
  logic              addr_err;
  logic              complete;
  logic              take;
  logic              commit_wr;
  logic              ctrl_wr;
  logic              init_start;
  logic              init_abort;
  logic [DATA_W-1:0] status_word;
  logic [DATA_W-1:0] rd_word;

`ifdef APB_PSTRB_EN
  assign strb_in = apb.pstrb;
`else
  assign strb_in = '1;
`endif

  // full word index is range-checked so out-of-range addresses never alias
  assign idx      = addr_q[IDX_W+1:2];
  assign addr_err = (addr_q[1:0] != 2'b00) ||
                    ({{(34-ADDR_W){1'b0}}, addr_q[ADDR_W-1:2]} >= $unsigned(NUM_REGS));
  assign complete = (state_q == ACCESS) && (wcnt_q == '0);
  assign take     = apb.psel && !apb.penable && ((state_q == IDLE) || complete);

  assign commit_wr  = complete && write_q && !addr_err;
  assign ctrl_wr    = commit_wr && (idx == CTRL_IDX) && strb_q[0];
  assign init_start = ctrl_wr && wdata_q[CTRL_START_BIT] && !wdata_q[CTRL_RST_BIT];
  assign init_abort = ctrl_wr && wdata_q[CTRL_RST_BIT];

  always_comb begin
    status_word                = '0;
    status_word[STAT_BUSY_BIT] = init_busy;
    status_word[STAT_DONE_BIT] = init_done;
    rd_word = (idx == STAT_IDX) ? status_word : regs_q[idx];
  end

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    strb_d   = strb_q;
    prdata_d = '0;
    if (take) begin
      addr_d  = apb.paddr;
      wdata_d = apb.pwdata;
      write_d = apb.pwrite;
      strb_d  = strb_in;
    end
    case (state_q)
      IDLE:    if (take) state_d = SETUP;
      SETUP: begin
        if (!apb.psel) begin
          state_d = IDLE;
        end else begin
          state_d = ACCESS;
          wcnt_d  = WCNT_W'(WAIT_CYCLES);
        end
      end
      ACCESS: begin
        if (wcnt_q != '0) begin
          if (!apb.psel) state_d = IDLE;
          else           wcnt_d  = wcnt_q - 1'b1;
        end else begin
          state_d = take ? SETUP : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // load read data on the edge that opens the pready cycle
    if ((state_d == ACCESS) && (wcnt_d == '0) && !write_q && !addr_err)
      prdata_d = rd_word;
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];
    if (commit_wr && (idx != STAT_IDX)) begin
      for (int b = 0; b < NBYTES; b++)
        if (strb_q[b]) regs_d[idx][b*8 +: 8] = wdata_q[b*8 +: 8];
    end
    regs_d[CTRL_IDX][CTRL_START_BIT] = 1'b0;
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q  <= IDLE;
      wcnt_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      strb_q   <= '0;
      prdata_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      regs_q[CTRL_IDX][CTRL_RST_BIT] <= 1'b1;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      strb_q   <= strb_d;
      prdata_q <= prdata_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  ddrc_init_timer #(
    .INIT_LATENCY (INIT_LATENCY)
  ) u_init_timer (
    .pclk   (pclk),
    .preset (preset),
    .start  (init_start),
    .abort  (init_abort),
    .busy   (init_busy),
    .done   (init_done)
  );

  assign apb.prdata  = prdata_q;
  assign apb.pready  = complete;
  assign apb.pslverr = complete && addr_err;
  assign ddrc_rst_o  = regs_q[CTRL_IDX][CTRL_RST_BIT];

endmodule
`default_nettype wire

// File: tb/tb_ddrc_apb_reg_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddrc_apb_reg_responder
// Brief    : Directed vector bench for the DDRC APB register responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddrc_apb_reg_responder;

  localparam int WAIT = 3;
  localparam int LAT  = 16;

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic pclk = 1'b0;
  logic preset;
  logic ddrc_rst_o, init_busy, init_done;
  int   checks = 0;
  int   errors = 0;

  ddrc_apb_reg_responder_if #(.ADDR_W(12), .DATA_W(32)) apb_bus ();

  ddrc_apb_reg_responder #(
    .ADDR_W(12), .DATA_W(32), .NUM_REGS(64),
    .WAIT_CYCLES(WAIT), .INIT_LATENCY(LAT)
  ) dut (
    .pclk       (pclk),
    .preset     (preset),
    .apb        (apb_bus),
    .ddrc_rst_o (ddrc_rst_o),
    .init_busy  (init_busy),
    .init_done  (init_done)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  // Entered and left at posedge+1 so consecutive calls are back-to-back.
  task automatic xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, output logic [31:0] rdata,
                      output logic err, output int lat, output logic ok);
    apb_bus.psel    = 1'b1;
    apb_bus.penable = 1'b0;
    apb_bus.pwrite  = wr;
    apb_bus.paddr   = addr;
    apb_bus.pwdata  = wdata;
`ifdef APB_PSTRB_EN
    apb_bus.pstrb   = strb;
`endif
    ok = 1'b0; rdata = '0; err = 1'b0;
    step();
    apb_bus.penable = 1'b1;
    lat = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge pclk);
      if (apb_bus.pready) begin
        ok = 1'b1; rdata = apb_bus.prdata; err = apb_bus.pslverr;
        break;
      end
      step();
      lat++;
    end
    if (ok) step();
    apb_bus.psel    = 1'b0;
    apb_bus.penable = 1'b0;
  endtask

  task automatic wr_reg(input string name, input logic [11:0] addr, input logic [31:0] d,
                        input logic [3:0] strb);
    logic [31:0] r; logic e, ok; int l;
    xfer(1'b1, addr, d, strb, r, e, l, ok);
    check({name, " ready"}, 32'(ok), 32'd1);
  endtask

  task automatic rd_chk(input string name, input logic [11:0] addr, input logic [31:0] exp);
    logic [31:0] r; logic e, ok; int l;
    xfer(1'b0, addr, 32'h0, 4'hF, r, e, l, ok);
    check({name, " ready"}, 32'(ok), 32'd1);
    check({name, " rdata"}, r, exp);
    check({name, " pslverr"}, 32'(e), 32'd0);
  endtask

  task automatic count_to_done(input int start_n, output int n);
    n = start_n;
    for (int i = 0; i < 60; i++) begin
      @(negedge pclk);
      if (init_done) break;
      n++;
      step();
    end
    step();
  endtask

  vec_t vecs [20];

  initial begin
    logic [31:0] r; logic e, ok; int l, n; logic seen;

    vecs[0]  = '{1'b0, 12'h000, 32'h0,        32'h0000_0001, 1'b0};
    vecs[1]  = '{1'b0, 12'h004, 32'h0,        32'h0,         1'b0};
    vecs[2]  = '{1'b1, 12'h010, 32'hDEADBEEF, 32'h0,         1'b0};
    vecs[3]  = '{1'b0, 12'h010, 32'h0,        32'hDEADBEEF,  1'b0};
    vecs[4]  = '{1'b1, 12'h014, 32'h13579BDF, 32'h0,         1'b0};
    vecs[5]  = '{1'b0, 12'h014, 32'h0,        32'h13579BDF,  1'b0};
    vecs[6]  = '{1'b0, 12'h010, 32'h0,        32'hDEADBEEF,  1'b0};
    vecs[7]  = '{1'b1, 12'h102, 32'h0000_0055, 32'h0,        1'b1};
    vecs[8]  = '{1'b0, 12'h100, 32'h0,        32'h0,         1'b1};
    vecs[9]  = '{1'b1, 12'h012, 32'h0,        32'h0,         1'b1};
    vecs[10] = '{1'b0, 12'h010, 32'h0,        32'hDEADBEEF,  1'b0};
    vecs[11] = '{1'b1, 12'h100, 32'h0,        32'h0,         1'b1};
    vecs[12] = '{1'b0, 12'h000, 32'h0,        32'h0000_0001, 1'b0};
    vecs[13] = '{1'b1, 12'h108, 32'h0000_0077, 32'h0,        1'b1};
    vecs[14] = '{1'b0, 12'h008, 32'h0,        32'h0,         1'b0};
    vecs[15] = '{1'b1, 12'h0FC, 32'hA5A5A5A5, 32'h0,         1'b0};
    vecs[16] = '{1'b0, 12'h0FC, 32'h0,        32'hA5A5A5A5,  1'b0};
    vecs[17] = '{1'b1, 12'h004, 32'hFFFFFFFF, 32'h0,         1'b0};
    vecs[18] = '{1'b0, 12'h004, 32'h0,        32'h0,         1'b0};
    vecs[19] = '{1'b0, 12'h0FE, 32'h0,        32'h0,         1'b1};

    apb_bus.psel = 1'b0; apb_bus.penable = 1'b0; apb_bus.pwrite = 1'b0;
    apb_bus.paddr = '0; apb_bus.pwdata = '0;
`ifdef APB_PSTRB_EN
    apb_bus.pstrb = '0;
`endif
    preset = 1'b1;
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;
    @(negedge pclk);
    check("reset pready", 32'(apb_bus.pready), 32'd0);
    check("reset pslverr", 32'(apb_bus.pslverr), 32'd0);
    check("reset prdata", apb_bus.prdata, 32'h0);
    check("reset ddrc_rst_o", 32'(ddrc_rst_o), 32'd1);
    check("reset init_busy", 32'(init_busy), 32'd0);
    check("reset init_done", 32'(init_done), 32'd0);
    step();

    for (int i = 0; i < 20; i++) begin
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 4'hF, r, e, l, ok);
      check($sformatf("vec%0d ready", i), 32'(ok), 32'd1);
      check($sformatf("vec%0d rdata", i), r, vecs[i].exp_rdata);
      check($sformatf("vec%0d pslverr", i), 32'(e), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d latency", i), 32'(l), 32'(WAIT + 2));
    end
    check("table ddrc_rst_o", 32'(ddrc_rst_o), 32'd1);

    // abort: psel dropped in the second ACCESS cycle
    wr_reg("abort pre", 12'h020, 32'h12345678, 4'hF);
    seen = 1'b0;
    apb_bus.psel = 1'b1; apb_bus.penable = 1'b0; apb_bus.pwrite = 1'b1;
    apb_bus.paddr = 12'h020; apb_bus.pwdata = 32'hCAFEF00D;
`ifdef APB_PSTRB_EN
    apb_bus.pstrb = 4'hF;
`endif
    @(negedge pclk); seen |= apb_bus.pready; step();
    apb_bus.penable = 1'b1;
    @(negedge pclk); seen |= apb_bus.pready; step();
    @(negedge pclk); seen |= apb_bus.pready; step();
    apb_bus.psel = 1'b0; apb_bus.penable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge pclk); seen |= apb_bus.pready; step();
    end
    check("abort no pready", 32'(seen), 32'd0);
    rd_chk("abort reg", 12'h020, 32'h12345678);

    // back-to-back pairs with no idle cycle
    wr_reg("b2b wr", 12'h030, 32'h0BADCAFE, 4'hF);
    rd_chk("b2b rd", 12'h030, 32'h0BADCAFE);
    wr_reg("b2b wr2", 12'h030, 32'h0000_0000, 4'hF);
    rd_chk("b2b rd2", 12'h030, 32'h0000_0000);

`ifdef APB_PSTRB_EN
    wr_reg("strb full", 12'h040, 32'h11223344, 4'hF);
    wr_reg("strb part", 12'h040, 32'hAABBCCDD, 4'b0101);
    rd_chk("strb rd", 12'h040, 32'h11BB33DD);
    wr_reg("strb ctrl", 12'h000, 32'h0000_0002, 4'hE);
    @(negedge pclk);
    check("strb no start", 32'(init_busy), 32'd0);
    check("strb rst kept", 32'(ddrc_rst_o), 32'd1);
    step();
`endif

    // init start and completion timing
    wr_reg("init start", 12'h000, 32'h0000_0002, 4'hF);
    @(negedge pclk);
    check("init busy next", 32'(init_busy), 32'd1);
    check("init rst_o", 32'(ddrc_rst_o), 32'd0);
    step();
    count_to_done(1, n);
    check("init latency", 32'(n), 32'(LAT));
    check("init busy off", 32'(init_busy), 32'd0);
    rd_chk("init status", 12'h004, 32'h0000_0002);
    rd_chk("init ctrl", 12'h000, 32'h0000_0000);

    wr_reg("init rst+start", 12'h000, 32'h0000_0003, 4'hF);
    rd_chk("rst status", 12'h004, 32'h0000_0000);
    rd_chk("rst ctrl", 12'h000, 32'h0000_0001);
    check("rst ddrc_rst_o", 32'(ddrc_rst_o), 32'd1);

    // second start while busy must not restart the countdown
    wr_reg("busy start1", 12'h000, 32'h0000_0002, 4'hF);
    xfer(1'b1, 12'h000, 32'h0000_0002, 4'hF, r, e, l, ok);
    check("busy start2 ready", 32'(ok), 32'd1);
    count_to_done(l + 1, n);
    check("busy ignore latency", 32'(n), 32'(LAT));

    // reset bit during countdown
    wr_reg("abort clr", 12'h000, 32'h0000_0003, 4'hF);
    wr_reg("abort start", 12'h000, 32'h0000_0002, 4'hF);
    wr_reg("abort rst", 12'h000, 32'h0000_0001, 4'hF);
    @(negedge pclk);
    check("abort busy", 32'(init_busy), 32'd0);
    step();
    repeat (20) step();
    @(negedge pclk);
    check("abort done", 32'(init_done), 32'd0);
    step();
    rd_chk("abort status", 12'h004, 32'h0000_0000);

    // preset in the middle of a countdown
    wr_reg("preset start", 12'h000, 32'h0000_0002, 4'hF);
    preset = 1'b1;
    step();
    preset = 1'b0;
    @(negedge pclk);
    check("preset busy", 32'(init_busy), 32'd0);
    check("preset done", 32'(init_done), 32'd0);
    check("preset rst_o", 32'(ddrc_rst_o), 32'd1);
    step();
    repeat (20) step();
    @(negedge pclk);
    check("preset done later", 32'(init_done), 32'd0);
    step();
    rd_chk("preset reg010", 12'h010, 32'h0);
    rd_chk("preset ctrl", 12'h000, 32'h0000_0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
